multicycle_processor: RTL

Parametrised multi-cycle successor to the single-cycle 16-bit core. Fetches 16-bit instructions from an external instruction memory over a req/ack handshake, so memories with wait states are supported. Executes each instruction through a FETCH/EXEC/WB state machine over an internal 8-entry register file. Adds PC-relative conditional branches, an absolute jump, HALT, and a per-instruction retire pulse. Sits at the top of the processor hierarchy in place of the single-cycle core.

---
 rtl/multicycle_processor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_processor.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_processor
// Purpose  : Multi-cycle 16-bit-instruction core. Each instruction goes
//            through FETCH (req/ack handshake), EXEC and WB. The core has an
//            8-entry register file, PC-relative BEQ/BNE, absolute JMP and HALT.
// Ports    : clk, reset (sync, active-low)
//            imem_req/imem_addr/imem_ack/imem_data : instruction fetch port
//            pc      : current program counter
//            retire  : one-cycle pulse in WB of each completed instruction
//            halted  : high once HALT has executed
//            zero    : last ADD/SUB/ADDI/SUBI result was zero
// Config   : `define MULTICYCLE_ZERO_REG_EN makes R0 read as 0 and ignore
//            writes. When it is undefined, R0 is an ordinary register.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_processor #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 10
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            zero
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   next_pc_q, next_pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];

  // Instruction fields
  logic [2:0] op, rd, rs1, rs2;
  assign op  = ir_q[15:13];
  assign rd  = ir_q[12:10];
  assign rs1 = ir_q[9:7];
  assign rs2 = ir_q[2:0];

  // Register file read ports (rd is also read, as the first BEQ/BNE operand)
  logic [DATA_W-1:0] rd_val, rs1_val, rs2_val;
  always_comb begin
    rd_val  = regs_q[rd];
    rs1_val = regs_q[rs1];
    rs2_val = regs_q[rs2];
`ifdef MULTICYCLE_ZERO_REG_EN
    if (rd  == 3'd0) rd_val  = '0;
    if (rs1 == 3'd0) rs1_val = '0;
    if (rs2 == 3'd0) rs2_val = '0;
`endif
  end

  // Writes to R0 are dropped only when the hard-wired zero register is enabled
  logic wr_allowed;
`ifdef MULTICYCLE_ZERO_REG_EN
  assign wr_allowed = (rd != 3'd0);
`else
  assign wr_allowed = 1'b1;
`endif

  // ALU and next-pc computation, both consumed in EXEC
  logic [DATA_W-1:0] imm4_ext;
  logic [PC_W-1:0]   imm7_ext, imm10_ext, pc_plus1;
  logic [DATA_W-1:0] alu_res;
  logic [PC_W-1:0]   npc;

  assign imm4_ext  = DATA_W'(ir_q[3:0]);
  assign imm7_ext  = PC_W'($signed(ir_q[6:0]));
  assign imm10_ext = PC_W'(ir_q[9:0]);
  assign pc_plus1  = pc_q + PC_W'(1);

  always_comb begin
    alu_res = '0;
    case (op)
      3'b000:  alu_res = rs1_val + rs2_val;
      3'b001:  alu_res = rs1_val - rs2_val;
      3'b010:  alu_res = rs1_val + imm4_ext;
      3'b011:  alu_res = rs1_val - imm4_ext;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    npc = pc_plus1;
    case (op)
      3'b100:  npc = (rd_val == rs1_val) ? (pc_q + imm7_ext) : pc_plus1;
      3'b101:  npc = (rd_val != rs1_val) ? (pc_q + imm7_ext) : pc_plus1;
      3'b110:  npc = imm10_ext;
      default: npc = pc_plus1;
    endcase
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    ir_d      = ir_q;
    result_d  = result_q;
    zero_d    = zero_q;
    regs_d    = regs_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d  = alu_res;
        next_pc_d = npc;
        state_d   = (op == 3'b111) ? S_HALT : S_WB;
      end
      S_WB: begin
        // op[2]==0 selects the four arithmetic instructions
        if (!op[2]) begin
          if (wr_allowed) regs_d[rd] = result_q;
          zero_d = (result_q == '0);
        end
        pc_d    = next_pc_q;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      next_pc_q <= '0;
      ir_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      ir_q      <= ir_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign retire    = (state_q == S_WB);
  assign halted    = (state_q == S_HALT);
  assign zero      = zero_q;

endmodule
`default_nettype wire
